// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg: shared definitions for the 8-bit RISC stored-program machine.
//   - datapath / field widths and instruction field offsets
//   - opcode constants, control-FSM state encoding
//   - Bus_1 / Bus_2 mux select codes
//   - ctrl_t: bundle of every strobe/select the control unit drives
package risc_spm_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int OP_SIZE    = 4;
  localparam int SEL1_SIZE  = 3;
  localparam int SEL2_SIZE  = 2;
  localparam int STATE_SIZE = 4;

  // Instruction fields: [7:4] opcode, [3:2] src, [1:0] dest
  localparam int OP_LSB   = 4;
  localparam int SRC_LSB  = 2;
  localparam int DEST_LSB = 0;

  localparam logic [OP_SIZE-1:0] OP_NOP = 4'd0;
  localparam logic [OP_SIZE-1:0] OP_ADD = 4'd1;
  localparam logic [OP_SIZE-1:0] OP_SUB = 4'd2;
  localparam logic [OP_SIZE-1:0] OP_AND = 4'd3;
  localparam logic [OP_SIZE-1:0] OP_NOT = 4'd4;
  localparam logic [OP_SIZE-1:0] OP_RD  = 4'd5;
  localparam logic [OP_SIZE-1:0] OP_WR  = 4'd6;
  localparam logic [OP_SIZE-1:0] OP_BR  = 4'd7;
  localparam logic [OP_SIZE-1:0] OP_BRZ = 4'd8;

  // Bus_1 select: registers R0..R3 occupy codes 0..3, PC is 4
  localparam logic [SEL1_SIZE-1:0] SEL1_R0 = 3'd0;
  localparam logic [SEL1_SIZE-1:0] SEL1_PC = 3'd4;

  // Bus_2 select
  localparam logic [SEL2_SIZE-1:0] SEL2_ALU  = 2'd0;
  localparam logic [SEL2_SIZE-1:0] SEL2_BUS1 = 2'd1;
  localparam logic [SEL2_SIZE-1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [STATE_SIZE-1:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  typedef struct packed {
    logic [3:0]           load_r;   // bit i loads Ri
    logic                 load_pc;
    logic                 inc_pc;
    logic [SEL1_SIZE-1:0] sel1;
    logic [SEL2_SIZE-1:0] sel2;
    logic                 load_ir;
    logic                 load_add_r;
    logic                 load_reg_y;
    logic                 load_reg_z;
    logic                 write;
  } ctrl_t;

  function automatic logic [OP_SIZE-1:0] get_opcode(input logic [WORD_SIZE-1:0] instr);
    return instr[OP_LSB +: OP_SIZE];
  endfunction

  function automatic logic [1:0] get_src(input logic [WORD_SIZE-1:0] instr);
    return instr[SRC_LSB +: 2];
  endfunction

  function automatic logic [1:0] get_dest(input logic [WORD_SIZE-1:0] instr);
    return instr[DEST_LSB +: 2];
  endfunction

  // Bus_1 select code for register Rn
  function automatic logic [SEL1_SIZE-1:0] reg_sel(input logic [1:0] r);
    return SEL1_R0 + {1'b0, r};
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// cu_output_decode: combinational strobe decode for the control FSM.
//   state        in   current FSM state
//   instruction  in   IR contents (opcode/src/dest used in S_DEC and later states)
//   Zflag        in   registered zero flag (only consulted for BRZ in S_DEC)
//   ctrl         out  every load/select/increment strobe plus memory write
// Anything not explicitly set in a state stays 0.
module cu_output_decode
  import risc_spm_pkg::*;
(
  input  state_t                 state,
  input  logic [WORD_SIZE-1:0]   instruction,
  input  logic                   Zflag,
  output ctrl_t                  ctrl
);

  logic [OP_SIZE-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;

  assign opcode = get_opcode(instruction);
  assign src    = get_src(instruction);
  assign dest   = get_dest(instruction);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FET1: begin
        ctrl.sel1       = SEL1_PC;
        ctrl.sel2       = SEL2_BUS1;
        ctrl.load_add_r = 1'b1;
      end
      S_FET2: begin
        ctrl.sel2    = SEL2_MEM;
        ctrl.load_ir = 1'b1;
        ctrl.inc_pc  = 1'b1;
      end
      S_DEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            ctrl.sel1       = reg_sel(src);
            ctrl.sel2       = SEL2_BUS1;
            ctrl.load_reg_y = 1'b1;
          end
          OP_NOT: begin
            ctrl.sel1       = reg_sel(src);
            ctrl.sel2       = SEL2_ALU;
            ctrl.load_r     = 4'b0001 << dest;
            ctrl.load_reg_z = 1'b1;
          end
          OP_RD, OP_WR, OP_BR: begin
            ctrl.sel1       = SEL1_PC;
            ctrl.sel2       = SEL2_BUS1;
            ctrl.load_add_r = 1'b1;
          end
          OP_BRZ: begin
            if (Zflag) begin
              ctrl.sel1       = SEL1_PC;
              ctrl.sel2       = SEL2_BUS1;
              ctrl.load_add_r = 1'b1;
            end else begin
              // Branch not taken: step PC past the target-address byte
              ctrl.inc_pc = 1'b1;
            end
          end
          default: ;  // NOP and illegal opcodes drive nothing
        endcase
      end
      S_EX1: begin
        ctrl.sel1       = reg_sel(dest);
        ctrl.sel2       = SEL2_ALU;
        ctrl.load_r     = 4'b0001 << dest;
        ctrl.load_reg_z = 1'b1;
      end
      S_RD1, S_WR1: begin
        // Operand byte holds the data address; latch it and step past it
        ctrl.sel2       = SEL2_MEM;
        ctrl.load_add_r = 1'b1;
        ctrl.inc_pc     = 1'b1;
      end
      S_RD2: begin
        ctrl.sel2   = SEL2_MEM;
        ctrl.load_r = 4'b0001 << dest;
      end
      S_WR2: begin
        ctrl.sel1  = reg_sel(src);
        ctrl.write = 1'b1;
      end
      S_BR1: begin
        ctrl.sel2       = SEL2_MEM;
        ctrl.load_add_r = 1'b1;
      end
      S_BR2: begin
        ctrl.sel2    = SEL2_MEM;
        ctrl.load_pc = 1'b1;
      end
      default: ;  // S_IDLE, S_HALT
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer for the 8-bit RISC-SPM.
//   clk, rst                 clock, synchronous active-high reset
//   instruction[7:0], Zflag  from the processing unit
//   Load_R0..Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R,
//   Load_Reg_Y, Load_Reg_Z   load/increment strobes
//   Sel_Bus_1_Mux[2:0], Sel_Bus_2_Mux[1:0]  bus source selects
//   write                    memory write (data = Bus_1, address = Add_R)
//   retire_cnt[15:0]         only when CU_RETIRE_CNT_EN is defined: count of
//                            instructions completed (wraps)
// All outputs are forced low while rst is high so an aborted instruction
// leaves no stray strobes.
module control_unit
  import risc_spm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  instruction,
  input  logic                  Zflag,
  output logic                  Load_R0,
  output logic                  Load_R1,
  output logic                  Load_R2,
  output logic                  Load_R3,
  output logic                  Load_PC,
  output logic                  Inc_PC,
  output logic [SEL1_SIZE-1:0]  Sel_Bus_1_Mux,
  output logic [SEL2_SIZE-1:0]  Sel_Bus_2_Mux,
  output logic                  Load_IR,
  output logic                  Load_Add_R,
  output logic                  Load_Reg_Y,
  output logic                  Load_Reg_Z,
  output logic                  write
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [15:0]           retire_cnt
`endif
);

  state_t state_reg;
  state_t state_next;
  ctrl_t  ctrl;
  ctrl_t  ctrl_gated;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: state_next = S_FET1;
      S_FET1: state_next = S_FET2;
      S_FET2: state_next = S_DEC;
      S_DEC: begin
        case (get_opcode(instruction))
          OP_NOP, OP_NOT:         state_next = S_FET1;
          OP_ADD, OP_SUB, OP_AND: state_next = S_EX1;
          OP_RD:                  state_next = S_RD1;
          OP_WR:                  state_next = S_WR1;
          OP_BR:                  state_next = S_BR1;
          OP_BRZ:                 state_next = Zflag ? S_BR1 : S_FET1;
          default:                state_next = S_HALT;
        endcase
      end
      S_EX1:  state_next = S_FET1;
      S_RD1:  state_next = S_RD2;
      S_RD2:  state_next = S_FET1;
      S_WR1:  state_next = S_WR2;
      S_WR2:  state_next = S_FET1;
      S_BR1:  state_next = S_BR2;
      S_BR2:  state_next = S_FET1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode
  cu_output_decode u_decode (
    .state       (state_reg),
    .instruction (instruction),
    .Zflag       (Zflag),
    .ctrl        (ctrl)
  );

  assign ctrl_gated = rst ? '0 : ctrl;

  assign Load_R0       = ctrl_gated.load_r[0];
  assign Load_R1       = ctrl_gated.load_r[1];
  assign Load_R2       = ctrl_gated.load_r[2];
  assign Load_R3       = ctrl_gated.load_r[3];
  assign Load_PC       = ctrl_gated.load_pc;
  assign Inc_PC        = ctrl_gated.inc_pc;
  assign Sel_Bus_1_Mux = ctrl_gated.sel1;
  assign Sel_Bus_2_Mux = ctrl_gated.sel2;
  assign Load_IR       = ctrl_gated.load_ir;
  assign Load_Add_R    = ctrl_gated.load_add_r;
  assign Load_Reg_Y    = ctrl_gated.load_reg_y;
  assign Load_Reg_Z    = ctrl_gated.load_reg_z;
  assign write         = ctrl_gated.write;

`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retire_cnt_reg;

  // An instruction retires when the FSM re-enters S_FET1 from anything but
  // S_IDLE (the first fetch after reset is not a retirement).
  always_ff @(posedge clk) begin
    if (rst)
      retire_cnt_reg <= '0;
    else if (state_next == S_FET1 && state_reg != S_IDLE)
      retire_cnt_reg <= retire_cnt_reg + 16'd1;
  end

  assign retire_cnt = retire_cnt_reg;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       Zflag;
  logic       Load_R0, Load_R1, Load_R2, Load_R3;
  logic       Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1_Mux;
  logic [1:0] Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write;
`ifdef CU_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Expected per-cycle control words for one instruction, starting at S_FET1
  logic [15:0] exp_v [0:7];
  int          exp_n;
  int          exp_retire;

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .Zflag         (Zflag),
    .Load_R0       (Load_R0),
    .Load_R1       (Load_R1),
    .Load_R2       (Load_R2),
    .Load_R3       (Load_R3),
    .Load_PC       (Load_PC),
    .Inc_PC        (Inc_PC),
    .Sel_Bus_1_Mux (Sel_Bus_1_Mux),
    .Sel_Bus_2_Mux (Sel_Bus_2_Mux),
    .Load_IR       (Load_IR),
    .Load_Add_R    (Load_Add_R),
    .Load_Reg_Y    (Load_Reg_Y),
    .Load_Reg_Z    (Load_Reg_Z),
    .write         (write)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retire_cnt    (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: [15:12] Load_R3..R0, [11] Load_PC, [10] Inc_PC, [9:7] Sel1,
  // [6:5] Sel2, [4] Load_IR, [3] Load_Add_R, [2] Load_Reg_Y, [1] Load_Reg_Z, [0] write
  function automatic logic [15:0] mk(input logic [3:0] ldr, input logic lpc, input logic ipc,
                                     input logic [2:0] s1, input logic [1:0] s2,
                                     input logic lir, input logic lar, input logic ly,
                                     input logic lz, input logic wr);
    return {ldr, lpc, ipc, s1, s2, lir, lar, ly, lz, wr};
  endfunction

  function automatic logic [15:0] obs();
    return {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
            Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write};
  endfunction

  // Reference model: the instruction's cycle-by-cycle control activity
  task automatic build_expect(input logic [7:0] ir, input logic z);
    int         op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] dhot;
    op   = int'(ir[7:4]);
    src  = {1'b0, ir[3:2]};
    dst  = {1'b0, ir[1:0]};
    dhot = 4'b0001 << ir[1:0];
    for (int i = 0; i < 8; i++) exp_v[i] = '0;
    exp_v[0] = mk(4'b0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0);  // PC -> Add_R
    exp_v[1] = mk(4'b0, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0);  // mem -> IR, PC+1
    exp_n = 3;
    if (op >= 1 && op <= 3) begin
      exp_v[2] = mk(4'b0, 0, 0, src, 2'd1, 0, 0, 1, 0, 0);
      exp_v[3] = mk(dhot, 0, 0, dst, 2'd0, 0, 0, 0, 1, 0);
      exp_n = 4;
    end else if (op == 4) begin
      exp_v[2] = mk(dhot, 0, 0, src, 2'd0, 0, 0, 0, 1, 0);
    end else if (op >= 5 && op <= 7 || (op == 8 && z)) begin
      exp_v[2] = mk(4'b0, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0);
      exp_n = 5;
      if (op == 5 || op == 6) exp_v[3] = mk(4'b0, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0);
      else                    exp_v[3] = mk(4'b0, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0);
      if (op == 5)      exp_v[4] = mk(dhot, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0);
      else if (op == 6) exp_v[4] = mk(4'b0, 0, 0, src, 2'd0, 0, 0, 0, 0, 1);
      else              exp_v[4] = mk(4'b0, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0);
    end else if (op == 8) begin
      exp_v[2] = mk(4'b0, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      instruction = 8'($urandom);
      Zflag = 1'($urandom);
      #1;
      compared++;
      if (obs() !== 16'h0) begin
        mismatched++;
        $display("FAIL reset_hold cyc%0d got %h want 0000", c, obs());
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (obs() !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_idle got %h want 0000", obs());
    end
    exp_retire = 0;
    $display("txn reset done");
  endtask

  task automatic test_add;
    int bad = 0;
    build_expect(8'h1B, 1'b0);
    for (int c = 0; c < exp_n; c++) begin
      @(negedge clk);
      if (c == 0) begin instruction = 8'h1B; Zflag = 1'b0; end
      #1;
      compared++;
      if (obs() !== exp_v[c]) begin
        mismatched++; bad++;
        $display("FAIL add cyc%0d got %h want %h", c, obs(), exp_v[c]);
      end
    end
    exp_retire++;
    $display("txn ADD R2,R3 ir=1b cycles=%0d bad=%0d", exp_n, bad);
  endtask

  task automatic test_rd;
    int bad = 0;
    build_expect(8'h52, 1'b0);
    for (int c = 0; c < exp_n; c++) begin
      @(negedge clk);
      if (c == 0) begin instruction = 8'h52; Zflag = 1'b0; end
      #1;
`ifdef CU_RETIRE_CNT_EN
      if (c == 0) begin
        compared++;
        if (retire_cnt !== 16'(exp_retire)) begin
          mismatched++;
          $display("FAIL retire_rd got %0d want %0d", retire_cnt, exp_retire);
        end
      end
`endif
      compared++;
      if (obs() !== exp_v[c]) begin
        mismatched++; bad++;
        $display("FAIL rd cyc%0d got %h want %h", c, obs(), exp_v[c]);
      end
    end
    exp_retire++;
    $display("txn RD R2 ir=52 cycles=%0d bad=%0d", exp_n, bad);
  endtask

  task automatic test_brz;
    for (int t = 0; t < 2; t++) begin
      int bad = 0;
      logic z;
      z = (t == 1);
      build_expect(8'h80, z);
      for (int c = 0; c < exp_n; c++) begin
        @(negedge clk);
        if (c == 0) begin instruction = 8'h80; Zflag = z; end
        #1;
        compared++;
        if (obs() !== exp_v[c]) begin
          mismatched++; bad++;
          $display("FAIL brz_z%0d cyc%0d got %h want %h", z, c, obs(), exp_v[c]);
        end
      end
      exp_retire++;
      $display("txn BRZ ir=80 z=%0d cycles=%0d bad=%0d", z, exp_n, bad);
    end
  endtask

  task automatic test_wr;
    int bad = 0;
    int writes = 0;
    build_expect(8'h63, 1'b1);
    for (int c = 0; c < exp_n; c++) begin
      @(negedge clk);
      if (c == 0) begin instruction = 8'h63; Zflag = 1'b1; end
      #1;
      writes += int'(write);
      compared++;
      if (obs() !== exp_v[c]) begin
        mismatched++; bad++;
        $display("FAIL wr cyc%0d got %h want %h", c, obs(), exp_v[c]);
      end
    end
    compared++;
    if (writes != 1) begin
      mismatched++;
      $display("FAIL wr_count got %0d want 1", writes);
    end
    exp_retire++;
    $display("txn WR R0 ir=63 cycles=%0d bad=%0d", exp_n, bad);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 60; n++) begin
      int bad = 0;
      logic [7:0] ir;
      logic z;
      ir = {4'($urandom_range(0, 8)), 4'($urandom)};
      z  = 1'($urandom);
      build_expect(ir, z);
      for (int c = 0; c < exp_n; c++) begin
        @(negedge clk);
        if (c == 0) begin instruction = ir; Zflag = z; end
        #1;
`ifdef CU_RETIRE_CNT_EN
        if (c == 0) begin
          compared++;
          if (retire_cnt !== 16'(exp_retire)) begin
            mismatched++;
            $display("FAIL retire_b2b got %0d want %0d", retire_cnt, exp_retire);
          end
        end
`endif
        compared++;
        if (obs() !== exp_v[c]) begin
          mismatched++; bad++;
          $display("FAIL b2b ir=%h z=%0d cyc%0d got %h want %h", ir, z, c, obs(), exp_v[c]);
        end
        compared++;
        if ((Load_PC && Inc_PC) || $countones({Load_R0, Load_R1, Load_R2, Load_R3}) > 1) begin
          mismatched++; bad++;
          $display("FAIL exclusive ir=%h cyc%0d got %h want one-hot-or-zero", ir, c, obs());
        end
      end
      exp_retire++;
      $display("txn b2b ir=%h z=%0d cycles=%0d bad=%0d", ir, z, exp_n, bad);
    end
  endtask

  task automatic test_reset_mid_rd;
    build_expect(8'h5D, 1'b0);
    for (int c = 0; c < 4; c++) begin   // stop after S_RD1
      @(negedge clk);
      if (c == 0) begin instruction = 8'h5D; Zflag = 1'b0; end
      #1;
      compared++;
      if (obs() !== exp_v[c]) begin
        mismatched++;
        $display("FAIL mid_rd cyc%0d got %h want %h", c, obs(), exp_v[c]);
      end
    end
    for (int c = 0; c < 3; c++) begin   // two cycles in reset, then the idle cycle
      @(negedge clk);
      rst = (c < 2);
      #1;
      compared++;
      if (obs() !== 16'h0) begin
        mismatched++;
        $display("FAIL mid_rd_reset cyc%0d got %h want 0000", c, obs());
      end
    end
    exp_retire = 0;
    $display("txn reset during RD, aborted");
  endtask

  task automatic test_halt;
    build_expect(8'hF0, 1'b0);
    for (int c = 0; c < 3 + 20; c++) begin
      @(negedge clk);
      if (c == 0) begin instruction = 8'hF0; Zflag = 1'b0; end
      #1;
      compared++;
      if (obs() !== ((c < 3) ? exp_v[c] : 16'h0)) begin
        mismatched++;
        $display("FAIL halt cyc%0d got %h want %h", c, obs(), (c < 3) ? exp_v[c] : 16'h0);
      end
`ifdef CU_RETIRE_CNT_EN
      compared++;
      if (retire_cnt !== 16'(exp_retire)) begin
        mismatched++;
        $display("FAIL retire_halt cyc%0d got %0d want %0d", c, retire_cnt, exp_retire);
      end
`endif
    end
    $display("txn HALT ir=f0 held 20 cycles");
  endtask

  initial begin
    rst = 1'b1;
    instruction = 8'h00;
    Zflag = 1'b0;
    exp_retire = 0;
    exp_n = 0;
    test_reset;
    test_add;
    test_rd;
    test_brz;
    test_wr;
    test_back_to_back;
    test_reset_mid_rd;
    test_halt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
